// File: rtl/hazard_ctrl.sv
// Issue/stall/flush control for a single-issue pipeline: a shift-pipe scoreboard of
// in-flight destinations for RAW interlocks, plus a one-cycle bnz resolve state.
module hazard_ctrl #(
    parameter int WB_LAT = 3,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rd,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_wr,
    input  logic             id_br,
    input  logic             ex_br_taken,
    output logic             issue,
    output logic             stall,
    output logic             flush,
    output logic             wb_en,
    output logic [4:0]       wb_rd,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {ST_RUN, ST_BR_WAIT} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WB_LAT-1:0] r_sb_v;
    logic [4:0]        r_sb_rd [WB_LAT];
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_hazard;
    logic              w_issue;
    logic              w_stall;
    logic              w_flush;
    logic              w_load;

    // The oldest entry is skipped: it is being written this cycle and the regfile forwards it.
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < WB_LAT - 1; i++) begin
            if (r_sb_v[i] && ((id_use_rs1 && (id_rs1 == r_sb_rd[i])) ||
                              (id_use_rs2 && (id_rs2 == r_sb_rd[i]))))
                w_hazard = 1'b1;
        end
        w_hazard = w_hazard && id_valid;
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_stall     = 1'b0;
        w_flush     = 1'b0;
        if (rst_n) begin
            case (r_state)
                ST_RUN: begin
                    w_issue = id_valid && !w_hazard;
                    w_stall = id_valid && !w_issue;
                    if (w_issue && id_br)
                        w_state_nxt = ST_BR_WAIT;
                end
                ST_BR_WAIT: begin
                    w_flush     = ex_br_taken;
                    w_stall     = !ex_br_taken;
                    w_state_nxt = ST_RUN;
                end
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    assign w_load = w_issue && id_wr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the scoreboard is a handful of flops, so every field is cleared; a stale
            // valid bit surviving reset would produce a phantom writeback.
            r_state     <= ST_RUN;
            r_sb_v      <= '0;
            for (int i = 0; i < WB_LAT; i++)
                r_sb_rd[i] <= 5'd0;
            r_stall_cnt <= '0;
        end else begin
            // NOTE: non-blocking so each entry takes its neighbour's pre-edge value.
            r_state    <= w_state_nxt;
            r_sb_v     <= {r_sb_v[WB_LAT-2:0], w_load};
            r_sb_rd[0] <= w_load ? id_rd : 5'd0;
            for (int i = 1; i < WB_LAT; i++)
                r_sb_rd[i] <= r_sb_rd[i-1];
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign issue     = w_issue;
    assign stall     = w_stall;
    assign flush     = w_flush;
    assign wb_en     = rst_n && r_sb_v[WB_LAT-1];
    assign wb_rd     = r_sb_rd[WB_LAT-1];
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a register-ready-time model of the interlock rules.
module tb_hazard_ctrl;
    localparam int WB_LAT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, id_valid, id_use_rs1, id_use_rs2, id_wr, id_br, ex_br_taken;
    logic [4:0] id_rd, id_rs1, id_rs2;
    logic       issue, stall, flush, wb_en;
    logic [4:0] wb_rd;
    logic [15:0] stall_cnt;
    logic       issue4, stall4, flush4, wb_en4;
    logic [4:0] wb_rd4;
    logic [3:0] stall_cnt4;

    hazard_ctrl #(.WB_LAT(WB_LAT), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rd(id_rd), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_wr(id_wr),
        .id_br(id_br), .ex_br_taken(ex_br_taken), .issue(issue), .stall(stall),
        .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .stall_cnt(stall_cnt));

    hazard_ctrl #(.WB_LAT(WB_LAT), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rd(id_rd), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_wr(id_wr),
        .id_br(id_br), .ex_br_taken(ex_br_taken), .issue(issue4), .stall(stall4),
        .flush(flush4), .wb_en(wb_en4), .wb_rd(wb_rd4), .stall_cnt(stall_cnt4));

    int n_checks = 0;
    int n_fail   = 0;

    // Model: each register's first readable cycle, the bnz resolve cycle, and writebacks by cycle.
    int         cyc;
    int         ready_at [32];
    int         br_wait_at;
    bit         wb_v [16];
    logic [4:0] wb_r [16];
    int         model_cnt;
    bit         e_issue, e_stall, e_flush, e_wb_en;
    logic [4:0] e_wb_rd;

    logic       o_issue, o_stall, o_flush, o_wb_en;
    logic [4:0] o_wb_rd;
    logic [15:0] o_cnt;
    logic [3:0] o_cnt4;
    logic       log_wb_en [64];
    logic [4:0] log_wb_rd [64];

    task automatic model_reset();
        for (int r = 0; r < 32; r++) ready_at[r] = 0;
        for (int s = 0; s < 16; s++) begin wb_v[s] = 1'b0; wb_r[s] = 5'd0; end
        br_wait_at = -1;
        model_cnt  = 0;
    endtask

    task automatic step();
        bit hz, in_br;
        int slot, exp16, exp4;
        @(negedge clk);
        slot = cyc % 16;
        if (!rst_n) begin
            e_issue = 0; e_stall = 0; e_flush = 0; e_wb_en = 0; e_wb_rd = 5'd0;
        end else begin
            hz      = id_valid && ((id_use_rs1 && ready_at[id_rs1] > cyc) ||
                                   (id_use_rs2 && ready_at[id_rs2] > cyc));
            in_br   = (br_wait_at == cyc);
            e_issue = !in_br && id_valid && !hz;
            e_flush = in_br && ex_br_taken;
            e_stall = in_br ? !ex_br_taken : (id_valid && !e_issue);
            e_wb_en = wb_v[slot];
            e_wb_rd = wb_r[slot];
        end
        exp16 = (model_cnt > 65535) ? 65535 : model_cnt;
        exp4  = (model_cnt > 15) ? 15 : model_cnt;
        n_checks++;
        if (issue !== e_issue) begin n_fail++; $display("FAIL issue cyc=%0d got=%b exp=%b", cyc, issue, e_issue); end
        n_checks++;
        if (stall !== e_stall) begin n_fail++; $display("FAIL stall cyc=%0d got=%b exp=%b", cyc, stall, e_stall); end
        n_checks++;
        if (flush !== e_flush) begin n_fail++; $display("FAIL flush cyc=%0d got=%b exp=%b", cyc, flush, e_flush); end
        n_checks++;
        if (wb_en !== e_wb_en) begin n_fail++; $display("FAIL wb_en cyc=%0d got=%b exp=%b", cyc, wb_en, e_wb_en); end
        if (e_wb_en) begin
            n_checks++;
            if (wb_rd !== e_wb_rd) begin n_fail++; $display("FAIL wb_rd cyc=%0d got=%0d exp=%0d", cyc, wb_rd, e_wb_rd); end
        end
        if (rst_n) begin
            n_checks++;
            if (stall_cnt !== 16'(exp16)) begin n_fail++; $display("FAIL stall_cnt cyc=%0d got=%0d exp=%0d", cyc, stall_cnt, exp16); end
            n_checks++;
            if (stall_cnt4 !== 4'(exp4)) begin n_fail++; $display("FAIL stall_cnt4 cyc=%0d got=%0d exp=%0d", cyc, stall_cnt4, exp4); end
        end
        o_issue = issue; o_stall = stall; o_flush = flush; o_wb_en = wb_en; o_wb_rd = wb_rd;
        o_cnt = stall_cnt; o_cnt4 = stall_cnt4;
        log_wb_en[cyc % 64] = wb_en;
        log_wb_rd[cyc % 64] = wb_rd;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            wb_v[slot] = 1'b0;
            if (e_stall) model_cnt++;
            if (e_issue && id_br) br_wait_at = cyc + 1;
            if (e_issue && id_wr) begin
                ready_at[id_rd]                = cyc + WB_LAT;
                wb_v[(cyc + WB_LAT) % 16]      = 1'b1;
                wb_r[(cyc + WB_LAT) % 16]      = id_rd;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        id_valid = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic set_instr(input logic [4:0] rd, rs1, rs2, input bit u1, u2, wr, br);
        id_valid = 1'b1; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        id_use_rs1 = u1; id_use_rs2 = u2; id_wr = wr; id_br = br;
    endtask

    // Holds one instruction in ID until the model says it issues (bounded).
    task automatic send(input logic [4:0] rd, rs1, rs2, input bit u1, u2, wr, br,
                        output int stalls, output int issue_at);
        set_instr(rd, rs1, rs2, u1, u2, wr, br);
        stalls   = 0;
        issue_at = -1;
        for (int k = 0; k < 16; k++) begin
            step();
            if (o_stall) stalls++;
            if (e_issue) begin issue_at = cyc - 1; break; end
        end
        n_checks++;
        if (issue_at < 0) begin n_fail++; $display("FAIL send_timeout rd=%0d got=no-issue exp=issue", rd); end
        id_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        id_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            n_checks++;
            if ({o_issue, o_stall, o_flush, o_wb_en} !== 4'b0) begin
                n_fail++; $display("FAIL reset_outputs got=%b exp=0000", {o_issue, o_stall, o_flush, o_wb_en});
            end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if ({o_issue, o_stall, o_flush, o_wb_en} !== 4'b0 || o_cnt !== 16'd0) begin
                n_fail++; $display("FAIL post_reset_idle got=%b cnt=%0d exp=0000 cnt=0", {o_issue, o_stall, o_flush, o_wb_en}, o_cnt);
            end
        end
    endtask

    task automatic test_raw_hazard();
        int st, at;
        send(5'd31, 5'd6, 5'd7, 1, 1, 1, 0, st, at);
        send(5'd2, 5'd31, 5'd0, 1, 0, 1, 0, st, at);
        n_checks++;
        if (st != 2) begin n_fail++; $display("FAIL raw_stalls got=%0d exp=2", st); end
        n_checks++;
        if (o_wb_en !== 1'b1 || o_wb_rd !== 5'd31) begin
            n_fail++; $display("FAIL raw_wb_at_issue got=%b/%0d exp=1/31", o_wb_en, o_wb_rd);
        end
        n_checks++;
        if (o_cnt !== 16'd2) begin n_fail++; $display("FAIL raw_stall_cnt got=%0d exp=2", o_cnt); end
        idle(4);
    endtask

    task automatic test_branch_taken();
        int st, at;
        ex_br_taken = 1'b0;
        send(5'd21, 5'd20, 5'd0, 1, 0, 1, 0, st, at);
        send(5'd20, 5'd21, 5'd0, 1, 0, 1, 0, st, at);
        send(5'd0, 5'd20, 5'd0, 1, 0, 0, 1, st, at);
        set_instr(5'd9, 5'd11, 5'd0, 1, 0, 1, 0);
        ex_br_taken = 1'b1;
        step();
        n_checks++;
        if (o_flush !== 1'b1 || o_stall !== 1'b0 || o_issue !== 1'b0) begin
            n_fail++; $display("FAIL br_taken_wait got f/s/i=%b%b%b exp=100", o_flush, o_stall, o_issue);
        end
        ex_br_taken = 1'b0;
        step();
        n_checks++;
        if (o_issue !== 1'b1 || o_flush !== 1'b0) begin
            n_fail++; $display("FAIL br_taken_resume got i/f=%b%b exp=10", o_issue, o_flush);
        end
        idle(4);
    endtask

    task automatic test_branch_not_taken();
        int st, at;
        ex_br_taken = 1'b0;
        send(5'd0, 5'd12, 5'd0, 1, 0, 0, 1, st, at);
        set_instr(5'd13, 5'd14, 5'd0, 1, 0, 1, 0);
        step();
        n_checks++;
        if (o_stall !== 1'b1 || o_flush !== 1'b0 || o_issue !== 1'b0) begin
            n_fail++; $display("FAIL br_nt_wait got s/f/i=%b%b%b exp=100", o_stall, o_flush, o_issue);
        end
        step();
        n_checks++;
        if (o_issue !== 1'b1) begin n_fail++; $display("FAIL br_nt_resume got=%b exp=1", o_issue); end
        idle(4);
    endtask

    task automatic test_back_to_back();
        int st, at, c0, total;
        total = 0;
        c0    = -1;
        for (int k = 1; k <= 5; k++) begin
            send(5'(k), 5'd10, 5'd0, 1, 0, 1, 0, st, at);
            if (k == 1) c0 = at;
            total += st;
            n_checks++;
            if (at != c0 + k - 1) begin n_fail++; $display("FAIL b2b_issue_cycle k=%0d got=%0d exp=%0d", k, at, c0 + k - 1); end
        end
        n_checks++;
        if (total != 0) begin n_fail++; $display("FAIL b2b_stalls got=%0d exp=0", total); end
        idle(6);
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (log_wb_en[(c0 + 3 + k) % 64] !== 1'b1 || log_wb_rd[(c0 + 3 + k) % 64] !== 5'(k + 1)) begin
                n_fail++; $display("FAIL b2b_wb k=%0d got=%b/%0d exp=1/%0d", k,
                                   log_wb_en[(c0 + 3 + k) % 64], log_wb_rd[(c0 + 3 + k) % 64], k + 1);
            end
        end
    endtask

    task automatic test_random();
        bit issued;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(3) == 0) begin
                id_valid = 1'b0;
                id_rs1 = 5'($urandom_range(7)); id_rs2 = 5'($urandom_range(7));
                ex_br_taken = 1'($urandom_range(1));
                step();
            end else begin
                set_instr(5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)),
                          1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1, 1'b0);
                if ($urandom_range(7) == 0) begin id_br = 1'b1; id_wr = 1'b0; end
                issued = 1'b0;
                for (int k = 0; k < 16 && !issued; k++) begin
                    ex_br_taken = 1'($urandom_range(1));
                    rst_n = ($urandom_range(63) != 0);
                    step();
                    rst_n = 1'b1;
                    issued = e_issue;
                end
                n_checks++;
                if (!issued) begin n_fail++; $display("FAIL random_timeout n=%0d got=no-issue exp=issue", n); end
            end
        end
        ex_br_taken = 1'b0;
        idle(4);
    endtask

    task automatic test_saturation();
        int st, at;
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        send(5'd1, 5'd0, 5'd0, 0, 0, 1, 0, st, at);
        for (int k = 2; k <= 10; k++) send(5'(k), 5'(k - 1), 5'd0, 1, 0, 1, 0, st, at);
        idle(1);
        send(5'd20, 5'd10, 5'd0, 1, 0, 1, 0, st, at);
        send(5'd0, 5'd0, 5'd0, 1, 0, 0, 1, st, at);
        n_checks++;
        if (o_cnt !== 16'd19) begin n_fail++; $display("FAIL sat_cnt16 got=%0d exp=19", o_cnt); end
        n_checks++;
        if (o_cnt4 !== 4'd15) begin n_fail++; $display("FAIL sat_cnt4 got=%0d exp=15", o_cnt4); end
        set_instr(5'd22, 5'd23, 5'd0, 1, 0, 0, 0);
        ex_br_taken = 1'b1;
        rst_n = 1'b0;
        step();
        n_checks++;
        if ({o_issue, o_stall, o_flush, o_wb_en} !== 4'b0) begin
            n_fail++; $display("FAIL sat_reset_in_brwait got=%b exp=0000", {o_issue, o_stall, o_flush, o_wb_en});
        end
        rst_n = 1'b1;
        ex_br_taken = 1'b0;
        step();
        n_checks++;
        if (o_issue !== 1'b1 || o_flush !== 1'b0) begin
            n_fail++; $display("FAIL sat_run_after_reset got i/f=%b%b exp=10", o_issue, o_flush);
        end
        n_checks++;
        if (o_cnt4 !== 4'd0 || o_cnt !== 16'd0) begin
            n_fail++; $display("FAIL sat_cnt_cleared got=%0d/%0d exp=0/0", o_cnt4, o_cnt);
        end
        id_valid = 1'b0;
        for (int k = 0; k < WB_LAT + 1; k++) begin
            step();
            n_checks++;
            if (o_wb_en !== 1'b0) begin n_fail++; $display("FAIL sat_stale_wb k=%0d got=%b exp=0", k, o_wb_en); end
        end
    endtask

    initial begin
        cyc = 0;
        rst_n = 1'b0; id_valid = 1'b0; id_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_wr = 1'b0; id_br = 1'b0; ex_br_taken = 1'b0;
        model_reset();
        test_reset();
        test_raw_hazard();
        test_branch_taken();
        test_branch_not_taken();
        test_back_to_back();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
